// File: rtl/lcd_write_driver.sv
// HD44780-style write-only bus driver: accepts one 9-bit word per data_ready/lcd_busy
// handshake and produces a timed RS/DB setup, E pulse, hold and execution wait.
module lcd_write_driver #(
  parameter int unsigned POWERUP_CYCLES = 750000,
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned E_PULSE_CYCLES = 12,
  parameter int unsigned HOLD_CYCLES    = 2,
  parameter int unsigned EXEC_CYCLES    = 2000,
  parameter int unsigned CLEAR_CYCLES   = 82000,
  parameter int unsigned COUNT_WIDTH    = 20
) (
  input  logic       clock,
  input  logic       internal_reset_n,
  input  logic [8:0] data_in,
  input  logic       data_ready,
  output logic       lcd_busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam logic [COUNT_WIDTH-1:0] PowerupLast = COUNT_WIDTH'(POWERUP_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] SetupLast   = COUNT_WIDTH'(SETUP_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] PulseLast   = COUNT_WIDTH'(E_PULSE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] HoldLast    = COUNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] ExecLast    = COUNT_WIDTH'(EXEC_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] ClearLast   = COUNT_WIDTH'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    StPowerup,
    StIdle,
    StSetup,
    StEnable,
    StHold,
    StExec,
    StRelease
  } state_e;

  state_e                 r_state;
  state_e                 w_state_next;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic [COUNT_WIDTH-1:0] w_cnt_next;
  logic [COUNT_WIDTH-1:0] w_exec_last;
  logic                   r_busy;
  logic                   r_rs;
  logic                   r_e;
  logic [7:0]             r_data;
  logic                   w_rs_next;
  logic [7:0]             w_data_next;
  logic                   w_is_clear;

  // Clear display / return home need the long execution wait.
  assign w_is_clear  = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02) || (r_data == 8'h03));
  assign w_exec_last = w_is_clear ? ClearLast : ExecLast;

  always_comb begin
    w_state_next = r_state;
    w_rs_next    = r_rs;
    w_data_next  = r_data;
    case (r_state)
      StPowerup: if (r_cnt == PowerupLast) w_state_next = StIdle;
      StIdle: begin
        if (data_ready) begin
          w_state_next = StSetup;
          w_rs_next    = data_in[8];
          w_data_next  = data_in[7:0];
        end
      end
      StSetup:   if (r_cnt == SetupLast)   w_state_next = StEnable;
      StEnable:  if (r_cnt == PulseLast)   w_state_next = StHold;
      StHold:    if (r_cnt == HoldLast)    w_state_next = StExec;
      StExec:    if (r_cnt == w_exec_last) w_state_next = StRelease;
      StRelease: if (!data_ready)          w_state_next = StIdle;
      default:   w_state_next = StPowerup;
    endcase

    // Untimed states park the counter at zero so it never wraps.
    if ((w_state_next != r_state) || (r_state == StIdle) || (r_state == StRelease)) begin
      w_cnt_next = '0;
    end else begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge internal_reset_n) begin
    if (!internal_reset_n) begin
      r_state <= StPowerup;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_e     <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_busy  <= (w_state_next != StIdle);
      r_e     <= (w_state_next == StEnable);
      r_rs    <= w_rs_next;
      r_data  <= w_data_next;
    end
  end

  assign lcd_busy = r_busy;
  assign lcd_rs   = r_rs;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = r_e;
  assign lcd_data = r_data;

endmodule
